// File: rtl/oled_refresh_sched_if.sv
// Signal bundle between the OLED refresh scheduler and its surroundings:
// live data in, the init/writer enable-FIN handshakes, snapshot out and status.
interface oled_refresh_sched_if;
    logic [31:0] din0;
    logic [31:0] din1;
    logic [31:0] din2;
    logic [31:0] din3;
    logic        force_refresh;
    logic        init_done;
    logic        update_done;
    logic        init_en;
    logic        update_en;
    logic        sel_init;
    logic        busy;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic [31:0] dout2;
    logic [31:0] dout3;
    logic [15:0] update_count;
    logic [2:0]  state_dbg;

    modport master (
        input  din0, din1, din2, din3, force_refresh, init_done, update_done,
        output init_en, update_en, sel_init, busy,
               dout0, dout1, dout2, dout3, update_count, state_dbg
    );

    modport slave (
        output din0, din1, din2, din3, force_refresh, init_done, update_done,
        input  init_en, update_en, sel_init, busy,
               dout0, dout1, dout2, dout3, update_count, state_dbg
    );
endinterface

// File: rtl/oled_refresh_sched.sv
// PmodOLED sequencer: runs init once after reset, then schedules rate-limited
// page-writer updates from a latched data snapshot.
module oled_refresh_sched #(
    parameter int unsigned REFRESH_CYCLES = 100_000_000,
    parameter int unsigned MIN_GAP        = 5_000_000
) (
    input  logic                 CLK100MHZ,
    input  logic                 RST,
    oled_refresh_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        ARM     = 3'd2,
        UPDATE  = 3'd3,
        RELEASE = 3'd4,
        HOLDOFF = 3'd5,
        WAIT    = 3'd6
    } state_t;

    localparam logic [31:0] REFRESH_LIMIT = 32'(REFRESH_CYCLES - 1);
    localparam logic [31:0] HOLDOFF_LAST  = 32'(MIN_GAP - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] refresh_cnt;
    logic [31:0] holdoff_cnt;
    logic        pending;
    logic [31:0] snap0;
    logic [31:0] snap1;
    logic [31:0] snap2;
    logic [31:0] snap3;
    logic [15:0] count;
    logic        data_changed;
    logic        refresh_due;
    logic        trigger;

    assign data_changed = {snap3, snap2, snap1, snap0} !=
                          {bus.din3, bus.din2, bus.din1, bus.din0};
    assign refresh_due  = refresh_cnt >= REFRESH_LIMIT;
    assign trigger      = data_changed | refresh_due | pending | bus.force_refresh;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = INIT;
            INIT:    if (bus.init_done) next_state = ARM;
            ARM:     next_state = UPDATE;
            UPDATE:  if (bus.update_done) next_state = RELEASE;
            RELEASE: if (!bus.update_done) next_state = HOLDOFF;
            HOLDOFF: if (holdoff_cnt == HOLDOFF_LAST) next_state = WAIT;
            WAIT:    if (trigger) next_state = ARM;
            default: next_state = IDLE;
        endcase
    end

    // Refresh counter restarts on ARM entry and advances every cycle, so two
    // back-to-back periodic ARMs land exactly REFRESH_CYCLES apart.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            refresh_cnt <= '0;
            holdoff_cnt <= '0;
            pending     <= 1'b0;
            snap0       <= '0;
            snap1       <= '0;
            snap2       <= '0;
            snap3       <= '0;
            count       <= '0;
        end else begin
            if (next_state == ARM) begin
                refresh_cnt <= '0;
            end else if (refresh_cnt != '1) begin
                refresh_cnt <= refresh_cnt + 32'd1;
            end

            if (state == RELEASE) begin
                holdoff_cnt <= '0;
            end else if (state == HOLDOFF) begin
                holdoff_cnt <= holdoff_cnt + 32'd1;
            end

            // A force arriving in the ARM cycle itself still wins over the clear.
            if (state == ARM) begin
                pending <= bus.force_refresh;
            end else if ((state == UPDATE || state == RELEASE || state == HOLDOFF) &&
                         bus.force_refresh) begin
                pending <= 1'b1;
            end

            if (state == ARM) begin
                snap0 <= bus.din0;
                snap1 <= bus.din1;
                snap2 <= bus.din2;
                snap3 <= bus.din3;
            end

            if (state == UPDATE && bus.update_done) begin
                count <= count + 16'd1;
            end
        end
    end

    assign bus.init_en      = (state == INIT);
    assign bus.update_en    = (state == UPDATE);
    assign bus.sel_init     = (state == IDLE) || (state == INIT);
    assign bus.busy         = (state != WAIT);
    assign bus.dout0        = snap0;
    assign bus.dout1        = snap1;
    assign bus.dout2        = snap2;
    assign bus.dout3        = snap3;
    assign bus.update_count = count;
    assign bus.state_dbg    = state;

endmodule
